// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package seq_onehot_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of one-hot outputs for an index of width aw.
  function automatic int unsigned oh_width(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/seq_onehot_decoder_dec.sv
// Combinational AW -> 2^AW one-hot decoder, gated to all-zero when inactive.
module onehot_dec
  import seq_onehot_decoder_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic [AW-1:0]            idx_i,
  input  logic                     act_i,
  output logic [oh_width(AW)-1:0]  q_c_o
);

  always_comb begin
    q_c_o = '0;
    if (act_i) q_c_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with a burst sequencer: static load, or a walking
// select over consecutive outputs with up/down, wrap/clamp and hold control.
module seq_onehot_decoder
  import seq_onehot_decoder_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_load,
  input  logic                     i_clr,
  input  logic                     i_start,
  input  logic [AW-1:0]            i_d,
  input  logic [AW:0]              i_len,
  input  logic                     i_dir,
  input  logic                     i_wrap,
  input  logic                     i_hold,
  output logic [oh_width(AW)-1:0]  o_q,
  output logic [AW-1:0]            o_idx,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int unsigned N  = oh_width(AW);
  localparam int unsigned CW = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d, idx_step;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            act_q, act_d;
  logic            dir_q, dir_d;
  logic            wrap_q, wrap_d;
  logic            err_d;
  logic            at_edge;
  logic [N-1:0]    q_dec;
  logic [N-1:0]    q_q;
  logic            busy_q, done_q, err_q;

  // Index step and edge detect in the latched direction; AW-bit math wraps mod N.
  assign idx_step = dir_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
  assign at_edge  = dir_q ? (idx_q == '0) : (idx_q == '1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_clr) begin
          act_d = 1'b0;
        end else if (i_start) begin
          if (i_len == '0) begin
            act_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d   = i_d;
            cnt_d   = i_len;
            dir_d   = i_dir;
            wrap_d  = i_wrap;
            act_d   = 1'b1;
            state_d = ST_RUN;
          end
        end else if (i_load) begin
          idx_d = i_d;
          act_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_clr) begin
          act_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (!i_hold) begin
          cnt_d = cnt_q - CW'(1);
          // Last beat wins over the edge check: a final beat at the edge is not a clamp.
          if (cnt_q == CW'(1)) begin
            act_d   = 1'b0;
            state_d = ST_DONE;
          end else if (!wrap_q && at_edge) begin
            act_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_step;
          end
        end
      end
      ST_DONE: begin
        act_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        act_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode from next-state so o_q is a true register aligned with o_idx.
  onehot_dec #(.AW(AW)) u_dec (
    .idx_i (idx_d),
    .act_i (act_d),
    .q_c_o (q_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      q_q     <= q_dec;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      err_q   <= err_d;
    end
  end

  assign o_q    = q_q;
  assign o_idx  = idx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed, table-driven bench for seq_onehot_decoder (AW=3 main, AW=1/4 sweeps).
module tb_seq_onehot_decoder;

  typedef struct {
    logic       load, clr, start, hold, dir, wrap;
    logic [2:0] d;
    logic [3:0] len;
    logic [7:0] q;
    logic [2:0] idx;
    logic       busy, done, err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic load, clr, start, hold, dir, wrap;
  logic [2:0] d;
  logic [3:0] len;
  logic [7:0] q3;
  logic [2:0] idx3;
  logic busy3, done3, err3;

  logic s1_start;
  logic [0:0] s1_d, idx1;
  logic [1:0] s1_len, q1;
  logic busy1, done1, err1;

  logic s4_start;
  logic [3:0] s4_d, idx4;
  logic [4:0] s4_len;
  logic [15:0] q4;
  logic busy4, done4, err4;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_onehot_decoder #(.AW(3)) u3 (
    .clk(clk), .reset_n(reset_n), .i_load(load), .i_clr(clr), .i_start(start),
    .i_d(d), .i_len(len), .i_dir(dir), .i_wrap(wrap), .i_hold(hold),
    .o_q(q3), .o_idx(idx3), .o_busy(busy3), .o_done(done3), .o_err(err3));

  seq_onehot_decoder #(.AW(1)) u1 (
    .clk(clk), .reset_n(reset_n), .i_load(load), .i_clr(clr), .i_start(s1_start),
    .i_d(s1_d), .i_len(s1_len), .i_dir(dir), .i_wrap(wrap), .i_hold(hold),
    .o_q(q1), .o_idx(idx1), .o_busy(busy1), .o_done(done1), .o_err(err1));

  seq_onehot_decoder #(.AW(4)) u4 (
    .clk(clk), .reset_n(reset_n), .i_load(load), .i_clr(clr), .i_start(s4_start),
    .i_d(s4_d), .i_len(s4_len), .i_dir(dir), .i_wrap(wrap), .i_hold(hold),
    .o_q(q4), .o_idx(idx4), .o_busy(busy4), .o_done(done4), .o_err(err4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic cl, input logic st, input logic ho,
                     input logic [2:0] dd, input logic [3:0] ln, input logic dr, input logic wr,
                     input logic [7:0] eq, input logic [2:0] ei, input logic eb,
                     input logic ed, input logic ee);
    vec_t v;
    v.load = ld; v.clr = cl; v.start = st; v.hold = ho; v.d = dd; v.len = ln;
    v.dir = dr; v.wrap = wr; v.q = eq; v.idx = ei; v.busy = eb; v.done = ed; v.err = ee;
    tbl.push_back(v);
  endtask

  task automatic nop(input logic [7:0] eq, input logic [2:0] ei, input logic eb,
                     input logic ed, input logic ee);
    add(0, 0, 0, 0, 3'd0, 4'd0, 0, 0, eq, ei, eb, ed, ee);
  endtask

  task automatic idle_inputs();
    load = 0; clr = 0; start = 0; hold = 0; dir = 0; wrap = 0; d = '0; len = '0;
    s1_start = 0; s1_d = '0; s1_len = '0; s4_start = 0; s4_d = '0; s4_len = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, beats;
    logic [15:0] seen;

    // Static load, hold for 10 cycles, then clear
    add(1, 0, 0, 0, 3'd5, 4'd0, 0, 0, 8'h20, 3'd5, 0, 0, 0);
    for (int k = 0; k < 10; k++) nop(8'h20, 3'd5, 0, 0, 0);
    add(0, 1, 0, 0, 3'd0, 4'd0, 0, 0, 8'h00, 3'd5, 0, 0, 0);
    // Up burst with wrap across N-1 -> 0
    add(0, 0, 1, 0, 3'd6, 4'd4, 0, 1, 8'h40, 3'd6, 1, 0, 0);
    nop(8'h80, 3'd7, 1, 0, 0);
    nop(8'h01, 3'd0, 1, 0, 0);
    nop(8'h02, 3'd1, 1, 0, 0);
    nop(8'h00, 3'd1, 0, 1, 0);
    nop(8'h00, 3'd1, 0, 0, 0);
    // Down burst clamped at 0
    add(0, 0, 1, 0, 3'd1, 4'd5, 1, 0, 8'h02, 3'd1, 1, 0, 0);
    nop(8'h01, 3'd0, 1, 0, 0);
    nop(8'h00, 3'd0, 0, 1, 1);
    nop(8'h00, 3'd0, 0, 0, 0);
    // Full-length burst with a 3-cycle hold on beat 3
    add(0, 0, 1, 0, 3'd0, 4'd8, 0, 1, 8'h01, 3'd0, 1, 0, 0);
    nop(8'h02, 3'd1, 1, 0, 0);
    nop(8'h04, 3'd2, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 3'd0, 4'd0, 0, 0, 8'h04, 3'd2, 1, 0, 0);
    nop(8'h08, 3'd3, 1, 0, 0);
    nop(8'h10, 3'd4, 1, 0, 0);
    nop(8'h20, 3'd5, 1, 0, 0);
    nop(8'h40, 3'd6, 1, 0, 0);
    nop(8'h80, 3'd7, 1, 0, 0);
    nop(8'h00, 3'd7, 0, 1, 0);
    nop(8'h00, 3'd7, 0, 0, 0);
    // Zero-length start: done pulse only, index untouched
    add(0, 0, 1, 0, 3'd3, 4'd0, 0, 0, 8'h00, 3'd7, 0, 1, 0);
    nop(8'h00, 3'd7, 0, 0, 0);
    // Start while running is ignored
    add(0, 0, 1, 0, 3'd2, 4'd3, 0, 1, 8'h04, 3'd2, 1, 0, 0);
    add(0, 0, 1, 0, 3'd7, 4'd1, 1, 0, 8'h08, 3'd3, 1, 0, 0);
    nop(8'h10, 3'd4, 1, 0, 0);
    nop(8'h00, 3'd4, 0, 1, 0);
    nop(8'h00, 3'd4, 0, 0, 0);
    // Clear at beat 2 aborts without done
    add(0, 0, 1, 0, 3'd3, 4'd4, 0, 0, 8'h08, 3'd3, 1, 0, 0);
    nop(8'h10, 3'd4, 1, 0, 0);
    add(0, 1, 0, 0, 3'd0, 4'd0, 0, 0, 8'h00, 3'd4, 0, 0, 0);
    nop(8'h00, 3'd4, 0, 0, 0);
    // Up burst clamped at N-1
    add(0, 0, 1, 0, 3'd6, 4'd5, 0, 0, 8'h40, 3'd6, 1, 0, 0);
    nop(8'h80, 3'd7, 1, 0, 0);
    nop(8'h00, 3'd7, 0, 1, 1);
    nop(8'h00, 3'd7, 0, 0, 0);
    // IDLE priorities: clr over start, start over load
    add(0, 1, 1, 0, 3'd2, 4'd3, 0, 0, 8'h00, 3'd7, 0, 0, 0);
    add(1, 0, 1, 0, 3'd1, 4'd2, 0, 1, 8'h02, 3'd1, 1, 0, 0);
    nop(8'h04, 3'd2, 1, 0, 0);
    nop(8'h00, 3'd2, 0, 1, 0);
    nop(8'h00, 3'd2, 0, 0, 0);
    // Final beat at the edge with no wrap is not a clamp
    add(0, 0, 1, 0, 3'd7, 4'd1, 0, 0, 8'h80, 3'd7, 1, 0, 0);
    nop(8'h00, 3'd7, 0, 1, 0);
    nop(8'h00, 3'd7, 0, 0, 0);
    // Successive loads, then clr beats hold in RUN
    add(1, 0, 0, 0, 3'd4, 4'd0, 0, 0, 8'h10, 3'd4, 0, 0, 0);
    add(1, 0, 0, 0, 3'd0, 4'd0, 0, 0, 8'h01, 3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 3'd0, 4'd3, 0, 1, 8'h01, 3'd0, 1, 0, 0);
    add(0, 1, 0, 1, 3'd0, 4'd0, 0, 0, 8'h00, 3'd0, 0, 0, 0);
    nop(8'h00, 3'd0, 0, 0, 0);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", 32'(q3), 32'h0);
    chk("reset_idx", 32'(idx3), 32'h0);
    chk("reset_busy", 32'(busy3), 32'h0);
    chk("reset_done", 32'(done3), 32'h0);
    chk("reset_err", 32'(err3), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      load = tbl[i].load; clr = tbl[i].clr; start = tbl[i].start; hold = tbl[i].hold;
      d = tbl[i].d; len = tbl[i].len; dir = tbl[i].dir; wrap = tbl[i].wrap;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_q", i), 32'(q3), 32'(tbl[i].q));
      chk($sformatf("row%0d_idx", i), 32'(idx3), 32'(tbl[i].idx));
      chk($sformatf("row%0d_busy", i), 32'(busy3), 32'(tbl[i].busy));
      chk($sformatf("row%0d_done", i), 32'(done3), 32'(tbl[i].done));
      chk($sformatf("row%0d_err", i), 32'(err3), 32'(tbl[i].err));
    end
    idle_inputs();

    // Reset asserted mid-run clears outputs immediately, no done afterwards
    start = 1; d = 3'd2; len = 4'd6; wrap = 1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("midrun_q_before", 32'(q3), 32'h08);
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_q", 32'(q3), 32'h0);
    chk("midrun_rst_busy", 32'(busy3), 32'h0);
    chk("midrun_rst_idx", 32'(idx3), 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrun_after_q", 32'(q3), 32'h0);
    chk("midrun_after_done", 32'(done3), 32'h0);
    chk("midrun_after_busy", 32'(busy3), 32'h0);

    // AW=1 full-length wrap sweep
    s1_start = 1; s1_d = 1'b0; s1_len = 2'd2; dir = 0; wrap = 1;
    @(posedge clk); #1;
    idle_inputs();
    seen = '0; beats = 0; cyc = 0;
    while (!done1 && cyc < 10) begin
      chk("sweep1_onehot", 32'($onehot(q1)), 32'h1);
      seen = seen | 16'(q1);
      beats++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("sweep1_done_seen", 32'(done1), 32'h1);
    chk("sweep1_beats", 32'(beats), 32'd2);
    chk("sweep1_cover", 32'(seen), 32'h3);
    chk("sweep1_err", 32'(err1), 32'h0);
    chk("sweep1_q_at_done", 32'(q1), 32'h0);

    // AW=4 full-length wrap sweep, counting down from 9
    s4_start = 1; s4_d = 4'd9; s4_len = 5'd16; dir = 1; wrap = 1;
    @(posedge clk); #1;
    idle_inputs();
    chk("sweep4_first", 32'(q4), 32'h0200);
    seen = '0; beats = 0; cyc = 0;
    while (!done4 && cyc < 24) begin
      chk("sweep4_onehot", 32'($onehot(q4)), 32'h1);
      seen = seen | q4;
      beats++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("sweep4_done_seen", 32'(done4), 32'h1);
    chk("sweep4_beats", 32'(beats), 32'd16);
    chk("sweep4_cover", 32'(seen), 32'hFFFF);
    chk("sweep4_err", 32'(err4), 32'h0);
    chk("sweep4_last_idx", 32'(idx4), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
